// File: rtl/ebus_pi_responder_if.sv
// EBUS signal bundle between the PI controller (master) and a device-side
// interrupt responder (slave). Bit vectors use EBUS numbering, bit 0 = MSB.
interface ebus_pi_responder_if;
  logic [2:0]  ebus_func;
  logic [0:6]  ebus_cs;
  logic        ebus_demand;
  logic [0:35] ebus_data_in;
  logic [0:7]  ebus_pi;
  logic [0:35] ebus_data_out;
  logic        ebus_driving;
  logic        ebus_xfer;

  modport master (
    output ebus_func, ebus_cs, ebus_demand, ebus_data_in,
    input  ebus_pi, ebus_data_out, ebus_driving, ebus_xfer
  );

  modport slave (
    input  ebus_func, ebus_cs, ebus_demand, ebus_data_in,
    output ebus_pi, ebus_data_out, ebus_driving, ebus_xfer
  );
endinterface

// File: rtl/ebus_pi_responder.sv
// EBUS device-side interrupt responder: holds a request at the PIA level,
// answers PI-serve with its physical-number bit and supplies the function word.
module ebus_pi_responder #(
  parameter logic [3:0]  PHY_NUM     = 4'd5,
  parameter logic [2:0]  FUNC_SERVE  = 3'd1,
  parameter logic [2:0]  FUNC_VECTOR = 3'd2,
  parameter int unsigned XFER_DLY    = 2
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  cono_pia_we,
  input  logic [2:0]            cono_pia,
  input  logic                  irq_set,
  input  logic                  irq_clr,
  input  logic [2:0]            fw_func,
  input  logic [17:0]           fw_addr,
  ebus_pi_responder_if.slave    bus,
  output logic                  pending,
  output logic [2:0]            pia,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SERVE, VWAIT, VXFER} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [2:0]  fw_func_q;
  logic [17:0] fw_addr_q;
  logic        start_lock;
  logic        arm, phy_match, vec_load, vec_done;

  assign arm       = bus.ebus_demand & ~start_lock & pending & (pia != 3'd0)
                     & (bus.ebus_cs[0:2] == pia);
  assign phy_match = (bus.ebus_data_in[7:10] == PHY_NUM);
  assign vec_load  = (state_q == IDLE) & (state_d == VWAIT);
  assign vec_done  = (state_q == VXFER) & ~bus.ebus_demand;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (arm && bus.ebus_func == FUNC_SERVE)
          state_d = SERVE;
        else if (arm && bus.ebus_func == FUNC_VECTOR && phy_match)
          state_d = VWAIT;
      end
      SERVE: if (!bus.ebus_demand) state_d = IDLE;
      VWAIT: begin
        if (!bus.ebus_demand)   state_d = IDLE;
        else if (cnt_q == 4'd0) state_d = VXFER;
      end
      VXFER: if (!bus.ebus_demand) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fw_func_q  <= '0;
      fw_addr_q  <= '0;
      start_lock <= 1'b0;
      pending    <= 1'b0;
      pia        <= '0;
    end else begin
      state_q <= state_d;
      if (vec_load) begin
        cnt_q     <= 4'(XFER_DLY - 1);
        fw_func_q <= fw_func;
        fw_addr_q <= fw_addr;
      end else if (state_q == VWAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Once a cycle has been taken, a demand that is still held must drop
      // before another start can be recognised.
      start_lock <= bus.ebus_demand & (start_lock | (state_q != IDLE));
      if (irq_set)                  pending <= 1'b1;
      else if (irq_clr || vec_done) pending <= 1'b0;
      if (cono_pia_we) pia <= cono_pia;
    end
  end

  // Bus outputs decode only from the state and latch registers.
  always_comb begin
    bus.ebus_data_out = '0;
    bus.ebus_driving  = 1'b0;
    bus.ebus_xfer     = 1'b0;
    unique case (state_q)
      SERVE: begin
        bus.ebus_driving           = 1'b1;
        bus.ebus_data_out[PHY_NUM] = 1'b1;
      end
      VXFER: begin
        bus.ebus_driving        = 1'b1;
        bus.ebus_xfer           = 1'b1;
        bus.ebus_data_out[3:5]  = fw_func_q;
        bus.ebus_data_out[18:35] = fw_addr_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.ebus_pi = '0;
    for (int unsigned n = 1; n < 8; n++)
      bus.ebus_pi[n] = pending & (pia == 3'(n));
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ebus_pi_responder.sv
// Directed bench for ebus_pi_responder: bus responses go through a scoreboard
// queue checked by a monitor; status flags are checked inline.
module tb_ebus_pi_responder;
  logic        clk = 1'b0;
  logic        RESET;
  logic        cono_pia_we;
  logic [2:0]  cono_pia;
  logic        irq_set, irq_clr;
  logic [2:0]  fw_func;
  logic [17:0] fw_addr;
  logic        pending;
  logic [2:0]  pia;
  logic        busy;

  ebus_pi_responder_if bus();

  ebus_pi_responder #(
    .PHY_NUM(4'd5), .FUNC_SERVE(3'd1), .FUNC_VECTOR(3'd2), .XFER_DLY(2)
  ) dut (
    .clk(clk), .RESET(RESET), .cono_pia_we(cono_pia_we), .cono_pia(cono_pia),
    .irq_set(irq_set), .irq_clr(irq_clr), .fw_func(fw_func), .fw_addr(fw_addr),
    .bus(bus), .pending(pending), .pia(pia), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:35] data;
    logic        xfer;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic drv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: each new drive window must match the next queued expectation.
  always @(negedge clk) begin
    if (!RESET && bus.ebus_driving && !drv_prev) begin
      if (q.size() == 0) begin
        chk("unexpected_drive", 36'(bus.ebus_data_out), 36'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_data", 36'(bus.ebus_data_out), 36'(e.data));
        chk("resp_xfer", 36'(bus.ebus_xfer), 36'(e.xfer));
        chk("resp_cycle", 36'(cyc), 36'(e.cyc));
      end
    end
    drv_prev <= bus.ebus_driving;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [0:35] vec_word(input logic [2:0] f, input logic [17:0] a);
    logic [0:35] w;
    w = '0;
    w[3:5]   = f;
    w[18:35] = a;
    return w;
  endfunction

  task automatic push(input logic [0:35] d, input logic x, input int lat);
    exp_t e;
    e.data = d;
    e.xfer = x;
    e.cyc  = cyc + lat;
    q.push_back(e);
  endtask

  logic [0:35] din_match, din_miss, serve_word;

  initial begin
    din_match = '0;  din_match[7:10] = 4'd5;
    din_miss  = '0;  din_miss[7:10]  = 4'd6;
    serve_word = 36'h1 << (35 - 5);

    RESET = 1'b1; cono_pia_we = 1'b0; cono_pia = '0; irq_set = 1'b0; irq_clr = 1'b0;
    fw_func = '0; fw_addr = '0;
    bus.ebus_func = '0; bus.ebus_cs = '0; bus.ebus_demand = 1'b0; bus.ebus_data_in = '0;
    tick(2);
    chk("rst_pi", 36'(bus.ebus_pi), 36'h0);
    chk("rst_data", 36'(bus.ebus_data_out), 36'h0);
    chk("rst_drv_xfer", {34'h0, bus.ebus_driving, bus.ebus_xfer}, 36'h0);
    chk("rst_pend_pia_busy", {31'h0, pending, pia, busy}, 36'h0);
    RESET = 1'b0;

    // 1: PIA and request lines
    cono_pia_we = 1'b1; cono_pia = 3'd3; irq_set = 1'b1;
    tick(1);
    cono_pia_we = 1'b0; irq_set = 1'b0;
    chk("pia3", 36'(pia), 36'd3);
    chk("pend_set", 36'(pending), 36'd1);
    chk("pi_lvl3", 36'(bus.ebus_pi), 36'b0001_0000);
    cono_pia_we = 1'b1; cono_pia = 3'd0; tick(1);
    chk("pi_disabled", 36'(bus.ebus_pi), 36'h0);
    cono_pia = 3'd3; tick(1); cono_pia_we = 1'b0;
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    chk("pend_clr", 36'(pending), 36'd0);
    irq_set = 1'b1; irq_clr = 1'b1; tick(1); irq_set = 1'b0; irq_clr = 1'b0;
    chk("set_wins", 36'(pending), 36'd1);

    // 2: serve at level 3
    bus.ebus_func = 3'd1; bus.ebus_cs = 7'b011_0000;
    push(serve_word, 1'b0, 1);
    bus.ebus_demand = 1'b1; tick(3);
    chk("serve_busy", 36'(busy), 36'd1);
    bus.ebus_demand = 1'b0; tick(1);
    chk("serve_release", {34'h0, bus.ebus_driving, pending}, 36'b01);

    // 3: vector with PHY match; word must come from the start-cycle latch
    bus.ebus_func = 3'd2; bus.ebus_data_in = din_match;
    fw_func = 3'd1; fw_addr = 18'o001234;
    push(vec_word(3'd1, 18'o001234), 1'b1, 3);
    bus.ebus_demand = 1'b1; tick(1);
    fw_func = 3'd7; fw_addr = 18'o777777;
    tick(4);
    chk("vec_xfer_hold", 36'(bus.ebus_xfer), 36'd1);
    bus.ebus_demand = 1'b0; tick(1);
    chk("vec_done_pend", 36'(pending), 36'd0);
    chk("vec_done_pi", 36'(bus.ebus_pi), 36'h0);
    chk("vec_done_bus", {34'h0, bus.ebus_driving, bus.ebus_xfer}, 36'h0);

    // 4: PHY mismatch and wrong level get no response
    irq_set = 1'b1; tick(1); irq_set = 1'b0;
    bus.ebus_data_in = din_miss;
    bus.ebus_demand = 1'b1; tick(5);
    chk("phy_miss_busy", 36'(busy), 36'd0);
    bus.ebus_demand = 1'b0; tick(1);
    chk("phy_miss_pend", 36'(pending), 36'd1);
    bus.ebus_func = 3'd1; bus.ebus_cs = 7'b100_0000;
    bus.ebus_demand = 1'b1; tick(3);
    chk("lvl_miss_busy", 36'(busy), 36'd0);
    bus.ebus_demand = 1'b0; tick(1);

    // 5: abort in VWAIT, then irq_set in the completion clock
    bus.ebus_func = 3'd2; bus.ebus_cs = 7'b011_0000; bus.ebus_data_in = din_match;
    fw_func = 3'd4; fw_addr = 18'o000777;
    bus.ebus_demand = 1'b1; tick(1);
    bus.ebus_demand = 1'b0; tick(1);
    chk("abort_idle", {33'h0, busy, bus.ebus_xfer, pending}, 36'b001);
    tick(3);
    push(vec_word(3'd4, 18'o000777), 1'b1, 3);
    bus.ebus_demand = 1'b1; tick(4);
    bus.ebus_demand = 1'b0; irq_set = 1'b1; tick(1); irq_set = 1'b0;
    chk("set_at_done", 36'(pending), 36'd1);

    // irq_clr during VWAIT still completes the selected cycle
    fw_func = 3'd2; fw_addr = 18'o123456;
    push(vec_word(3'd2, 18'o123456), 1'b1, 3);
    bus.ebus_demand = 1'b1; tick(1);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    chk("clr_in_vwait", 36'(pending), 36'd0);
    tick(3);
    bus.ebus_demand = 1'b0; tick(1);

    // 6: reset during VXFER
    irq_set = 1'b1; tick(1); irq_set = 1'b0;
    fw_func = 3'd5; fw_addr = 18'o070707;
    push(vec_word(3'd5, 18'o070707), 1'b1, 3);
    bus.ebus_demand = 1'b1; tick(4);
    RESET = 1'b1; tick(1);
    chk("rst_mid_bus", {34'h0, bus.ebus_driving, bus.ebus_xfer}, 36'h0);
    chk("rst_mid_data", 36'(bus.ebus_data_out), 36'h0);
    chk("rst_mid_state", {31'h0, pending, pia, busy}, 36'h0);
    RESET = 1'b0; bus.ebus_demand = 1'b0;
    tick(3);

    chk("queue_drained", 36'(q.size()), 36'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
